// File: rtl/pll_ctrl_pkg.sv
// Shared types for the rPLL reconfiguration sequencer: FSM states, divider-select
// bundle and a counter-width helper.
package pll_ctrl_pkg;

    localparam int PLL_SEL_W = 6;

    typedef enum logic [1:0] {
        ST_RESET,
        ST_WAIT_LOCK,
        ST_LOCKED,
        ST_FAIL
    } pll_state_e;

    typedef struct packed {
        logic [PLL_SEL_W-1:0] idsel;
        logic [PLL_SEL_W-1:0] fbdsel;
        logic [PLL_SEL_W-1:0] odsel;
    } pll_sel_t;

    // Width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pll_reconfig_ctrl_if.sv
// Divider-change request channel: valid/ready handshake plus a done pulse on relock.
interface pll_reconfig_ctrl_if;
    import pll_ctrl_pkg::*;

    logic                 cfg_valid;
    logic [PLL_SEL_W-1:0] cfg_idsel;
    logic [PLL_SEL_W-1:0] cfg_fbdsel;
    logic [PLL_SEL_W-1:0] cfg_odsel;
    logic                 cfg_ready;
    logic                 cfg_done;

    modport master (
        output cfg_valid, cfg_idsel, cfg_fbdsel, cfg_odsel,
        input  cfg_ready, cfg_done
    );

    modport slave (
        input  cfg_valid, cfg_idsel, cfg_fbdsel, cfg_odsel,
        output cfg_ready, cfg_done
    );
endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous level signal.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/pll_reconfig_ctrl.sv
// Gowin rPLL reset/divider sequencer with lock qualification, timeout retries and
// runtime divider changes. Define PLL_CTRL_STATS_EN to add lock-loss/retry counters.
module pll_reconfig_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int                   RESET_CYCLES        = 16,
    parameter int                   LOCK_STABLE_CYCLES  = 256,
    parameter int                   LOCK_TIMEOUT_CYCLES = 65535,
    parameter int                   MAX_RETRIES         = 3,
    parameter logic [PLL_SEL_W-1:0] DEF_IDSEL           = '0,
    parameter logic [PLL_SEL_W-1:0] DEF_FBDSEL          = '0,
    parameter logic [PLL_SEL_W-1:0] DEF_ODSEL           = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pll_lock,
    output logic                 pll_reset,
    output logic [PLL_SEL_W-1:0] idsel,
    output logic [PLL_SEL_W-1:0] fbdsel,
    output logic [PLL_SEL_W-1:0] odsel,
    output logic                 locked,
    output logic                 fail,
`ifdef PLL_CTRL_STATS_EN
    output logic [7:0]           lock_loss_cnt,
    output logic [7:0]           retry_total,
`endif
    pll_reconfig_ctrl_if.slave   cfg
);
    // One timer serves both the reset window and the lock timeout.
    localparam int TMR_W = (cnt_w(RESET_CYCLES) > cnt_w(LOCK_TIMEOUT_CYCLES)) ?
                           cnt_w(RESET_CYCLES) : cnt_w(LOCK_TIMEOUT_CYCLES);
    localparam int STB_W = cnt_w(LOCK_STABLE_CYCLES);
    localparam int RTY_W = cnt_w(MAX_RETRIES + 1);

    localparam logic [TMR_W-1:0] RST_TC  = TMR_W'(RESET_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMO_TC  = TMR_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [STB_W-1:0] STB_TC  = STB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRIES);

    pll_state_e       state;
    pll_sel_t         sel;
    logic [TMR_W-1:0] tmr;
    logic [STB_W-1:0] stb;
    logic [RTY_W-1:0] retry_cnt;
    logic             lock_s;
    logic             cfg_ready_q;
    logic             cfg_done_q;
    logic             pending;
    logic             accept;

    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_lock),
        .q   (lock_s)
    );

    assign accept        = cfg.cfg_valid && cfg_ready_q;
    assign cfg.cfg_ready = cfg_ready_q;
    assign cfg.cfg_done  = cfg_done_q;
    assign idsel         = sel.idsel;
    assign fbdsel        = sel.fbdsel;
    assign odsel         = sel.odsel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_RESET;
            pll_reset   <= 1'b1;
            sel         <= '{idsel: DEF_IDSEL, fbdsel: DEF_FBDSEL, odsel: DEF_ODSEL};
            cfg_ready_q <= 1'b0;
            cfg_done_q  <= 1'b0;
            locked      <= 1'b0;
            fail        <= 1'b0;
            retry_cnt   <= '0;
            tmr         <= '0;
            stb         <= '0;
            pending     <= 1'b0;
`ifdef PLL_CTRL_STATS_EN
            lock_loss_cnt <= '0;
            retry_total   <= '0;
`endif
        end else begin
            cfg_done_q <= 1'b0;
            if (accept) begin
                // Selects move on the same edge pll_reset rises, so the PLL never sees them change while running.
                sel         <= '{idsel: cfg.cfg_idsel, fbdsel: cfg.cfg_fbdsel, odsel: cfg.cfg_odsel};
                locked      <= 1'b0;
                cfg_ready_q <= 1'b0;
                fail        <= 1'b0;
                retry_cnt   <= '0;
                pending     <= 1'b1;
                state       <= ST_RESET;
                pll_reset   <= 1'b1;
                tmr         <= '0;
                stb         <= '0;
            end else begin
                case (state)
                    ST_RESET: begin
                        if (tmr == RST_TC) begin
                            state     <= ST_WAIT_LOCK;
                            pll_reset <= 1'b0;
                            tmr       <= '0;
                            stb       <= '0;
                        end else if (tmr != '1) begin
                            tmr <= tmr + 1'b1;
                        end
                    end
                    ST_WAIT_LOCK: begin
                        if (lock_s && stb == STB_TC) begin
                            state       <= ST_LOCKED;
                            locked      <= 1'b1;
                            cfg_ready_q <= 1'b1;
                            retry_cnt   <= '0;
                            cfg_done_q  <= pending;
                            pending     <= 1'b0;
                        end else if (tmr == TMO_TC) begin
                            tmr       <= '0;
                            stb       <= '0;
                            pll_reset <= 1'b1;
                            if (retry_cnt < RTY_MAX) begin
                                retry_cnt <= retry_cnt + 1'b1;
                                state     <= ST_RESET;
`ifdef PLL_CTRL_STATS_EN
                                if (retry_total != 8'hFF) retry_total <= retry_total + 8'd1;
`endif
                            end else begin
                                state       <= ST_FAIL;
                                fail        <= 1'b1;
                                cfg_ready_q <= 1'b1;
                            end
                        end else begin
                            if (tmr != '1) tmr <= tmr + 1'b1;
                            if (!lock_s)       stb <= '0;
                            else if (stb != '1) stb <= stb + 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        if (!lock_s) begin
                            state       <= ST_RESET;
                            locked      <= 1'b0;
                            cfg_ready_q <= 1'b0;
                            retry_cnt   <= '0;
                            pll_reset   <= 1'b1;
                            tmr         <= '0;
                            stb         <= '0;
`ifdef PLL_CTRL_STATS_EN
                            if (lock_loss_cnt != 8'hFF) lock_loss_cnt <= lock_loss_cnt + 8'd1;
`endif
                        end
                    end
                    ST_FAIL: begin
                    end
                    default: begin
                        state     <= ST_RESET;
                        pll_reset <= 1'b1;
                        tmr       <= '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Bench for pll_reconfig_ctrl: directed vector table, corner sequences and random
// stimulus, all cross-checked every cycle against a phase-level reference model.
module tb_pll_reconfig_ctrl;
    localparam int RC = 4;
    localparam int SC = 8;
    localparam int TC = 32;
    localparam int MR = 2;
    localparam logic [22:0] RST_VEC = 23'h400000;

    localparam int M_RST  = 0;
    localparam int M_WAIT = 1;
    localparam int M_LOCK = 2;
    localparam int M_FAIL = 3;

    logic       clk;
    logic       rst;
    logic       pll_lock;
    logic       pll_reset;
    logic [5:0] idsel;
    logic [5:0] fbdsel;
    logic [5:0] odsel;
    logic       locked;
    logic       fail;
`ifdef PLL_CTRL_STATS_EN
    logic [7:0] lock_loss_cnt;
    logic [7:0] retry_total;
`endif

    pll_reconfig_ctrl_if cfg_if ();

    pll_reconfig_ctrl #(
        .RESET_CYCLES        (RC),
        .LOCK_STABLE_CYCLES  (SC),
        .LOCK_TIMEOUT_CYCLES (TC),
        .MAX_RETRIES         (MR),
        .DEF_IDSEL           (6'd0),
        .DEF_FBDSEL          (6'd0),
        .DEF_ODSEL           (6'd0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pll_lock      (pll_lock),
        .pll_reset     (pll_reset),
        .idsel         (idsel),
        .fbdsel        (fbdsel),
        .odsel         (odsel),
        .locked        (locked),
        .fail          (fail),
`ifdef PLL_CTRL_STATS_EN
        .lock_loss_cnt (lock_loss_cnt),
        .retry_total   (retry_total),
`endif
        .cfg           (cfg_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: phase, edges spent in it, and the lock_s history per edge.
    int         m_mode;
    int         m_len;
    int         m_retries;
    int         m_loss;
    int         m_rtot;
    bit         m_pending;
    bit         m_done;
    logic [5:0] m_id, m_fb, m_od;
    bit         lk_app[$];
    bit         ls_seen[$];

    function automatic void model_reset();
        m_mode = M_RST; m_len = 0; m_retries = 0; m_loss = 0; m_rtot = 0;
        m_pending = 0; m_done = 0; m_id = 0; m_fb = 0; m_od = 0;
        lk_app.delete(); ls_seen.delete();
    endfunction

    function automatic void enter(input int m);
        m_mode = m;
        m_len  = 0;
    endfunction

    function automatic void model_edge(input bit lk, input bit v,
                                       input logic [5:0] ci, input logic [5:0] cf, input logic [5:0] co);
        bit ls;
        bit stable;
        ls = (lk_app.size() >= 2) ? lk_app[lk_app.size()-2] : 1'b0;
        lk_app.push_back(lk);
        ls_seen.push_back(ls);
        m_done = 0;
        if (v && (m_mode == M_LOCK || m_mode == M_FAIL)) begin
            m_id = ci; m_fb = cf; m_od = co;
            m_pending = 1; m_retries = 0;
            enter(M_RST);
        end else begin
            case (m_mode)
                M_RST: begin
                    m_len++;
                    if (m_len == RC) enter(M_WAIT);
                end
                M_WAIT: begin
                    m_len++;
                    stable = (m_len >= SC);
                    for (int j = 0; j < SC; j++)
                        if (stable && !ls_seen[ls_seen.size()-1-j]) stable = 0;
                    if (stable) begin
                        m_done = m_pending; m_pending = 0; m_retries = 0;
                        enter(M_LOCK);
                    end else if (m_len == TC) begin
                        if (m_retries < MR) begin
                            m_retries++;
                            if (m_rtot < 255) m_rtot++;
                            enter(M_RST);
                        end else begin
                            enter(M_FAIL);
                        end
                    end
                end
                M_LOCK: begin
                    if (!ls) begin
                        if (m_loss < 255) m_loss++;
                        m_retries = 0;
                        enter(M_RST);
                    end
                end
                default: begin
                end
            endcase
        end
    endfunction

    function automatic logic [22:0] model_vec();
        logic pr, lo, fa, rd;
        pr = (m_mode == M_RST) || (m_mode == M_FAIL);
        lo = (m_mode == M_LOCK);
        fa = (m_mode == M_FAIL);
        rd = (m_mode == M_LOCK) || (m_mode == M_FAIL);
        return {pr, lo, fa, rd, m_done, m_id, m_fb, m_od};
    endfunction

    function automatic logic [22:0] act_vec();
        return {pll_reset, locked, fail, cfg_if.cfg_ready, cfg_if.cfg_done, idsel, fbdsel, odsel};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step(input bit lk, input bit v,
                        input logic [5:0] ci, input logic [5:0] cf, input logic [5:0] co);
        pll_lock          = lk;
        cfg_if.cfg_valid  = v;
        cfg_if.cfg_idsel  = ci;
        cfg_if.cfg_fbdsel = cf;
        cfg_if.cfg_odsel  = co;
        @(posedge clk);
        model_edge(lk, v, ci, cf, co);
        @(negedge clk);
        check($sformatf("cycle%0d", cyc), 32'(act_vec()), 32'(model_vec()));
`ifdef PLL_CTRL_STATS_EN
        check($sformatf("stats%0d", cyc), {16'd0, lock_loss_cnt, retry_total},
              {16'd0, 8'(m_loss), 8'(m_rtot)});
`endif
        cyc++;
    endtask

    typedef struct {
        bit          lk;
        bit          v;
        logic [5:0]  ci, cf, co;
        int          n;
        logic [22:0] exp;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input bit lk, input bit v, input logic [5:0] ci, input logic [5:0] cf,
                                input logic [5:0] co, input int n, input bit pr, input bit lo,
                                input bit fa, input bit rd, input bit dn,
                                input logic [5:0] ei, input logic [5:0] ef, input logic [5:0] eo);
        vec_t r;
        r.lk = lk; r.v = v; r.ci = ci; r.cf = cf; r.co = co; r.n = n;
        r.exp = {pr, lo, fa, rd, dn, ei, ef, eo};
        tbl.push_back(r);
    endfunction

    initial begin
        int cnt;
        int falls;
        int f_at[3];
        int dones;
        bit prev_pr;
        bit lv;
        int run;

        rst = 1'b1; pll_lock = 1'b1;
        cfg_if.cfg_valid = 0; cfg_if.cfg_idsel = 0; cfg_if.cfg_fbdsel = 0; cfg_if.cfg_odsel = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_state", 32'(act_vec()), 32'(RST_VEC));
        rst = 1'b0;

        // Lock from power-up, a request, lock loss with retries into FAIL, recovery request.
        add(1,0, 0,0,0,  3, 1,0,0,0,0, 0,0,0);
        add(1,0, 0,0,0,  1, 0,0,0,0,0, 0,0,0);
        add(1,0, 0,0,0,  7, 0,0,0,0,0, 0,0,0);
        add(1,0, 0,0,0,  1, 0,1,0,1,0, 0,0,0);
        add(1,1, 3,9,8,  1, 1,0,0,0,0, 3,9,8);
        add(1,0, 0,0,0, 11, 0,0,0,0,0, 3,9,8);
        add(1,0, 0,0,0,  1, 0,1,0,1,1, 3,9,8);
        add(1,0, 0,0,0,  1, 0,1,0,1,0, 3,9,8);
        add(0,0, 0,0,0,  3, 1,0,0,0,0, 3,9,8);
        add(0,0, 0,0,0,  4, 0,0,0,0,0, 3,9,8);
        add(0,0, 0,0,0, 32, 1,0,0,0,0, 3,9,8);
        add(0,0, 0,0,0, 72, 1,0,1,1,0, 3,9,8);
        add(0,0, 0,0,0,  1, 1,0,1,1,0, 3,9,8);
        add(1,1, 5,1,2,  1, 1,0,0,0,0, 5,1,2);
        add(1,0, 0,0,0, 12, 0,1,0,1,1, 5,1,2);
        for (int i = 0; i < tbl.size(); i++) begin
            for (int k = 0; k < tbl[i].n; k++) step(tbl[i].lk, tbl[i].v, tbl[i].ci, tbl[i].cf, tbl[i].co);
            check($sformatf("tbl%0d", i), 32'(act_vec()), 32'(tbl[i].exp));
        end

        // Glitchy lock during WAIT_LOCK restarts the stability window.
        step(1, 1, 6'd7, 6'd7, 6'd7);
        repeat (6) step(0, 0, 0, 0, 0);
        repeat (5) step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        cnt = 0;
        while (!locked && cnt < 60) begin
            step(1, 0, 0, 0, 0);
            cnt++;
        end
        check("glitch_relock_cycles", 32'(cnt), 32'd10);
        check("glitch_done", 32'(cfg_if.cfg_done), 32'd1);

        // Single-cycle lock drop in LOCKED: locked falls after sync + register, same selects.
        cnt = 0;
        step(0, 0, 0, 0, 0);
        cnt++;
        while (locked && cnt < 10) begin
            step(1, 0, 0, 0, 0);
            cnt++;
        end
        check("loss_latency", 32'(cnt), 32'd3);
        cnt = 0;
        while (!locked && cnt < 40) begin
            step(1, 0, 0, 0, 0);
            cnt++;
        end
        check("auto_relock", 32'(locked), 32'd1);
        check("auto_relock_sel", 32'({idsel, fbdsel, odsel}), 32'({6'd7, 6'd7, 6'd7}));
`ifdef PLL_CTRL_STATS_EN
        check("lock_loss_cnt", 32'(lock_loss_cnt), 32'd2);
        check("retry_total", 32'(retry_total), 32'd2);
`endif

        // No lock from reset: three reset pulses 36 cycles apart, then FAIL.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        falls = 0; prev_pr = 1'b1; cnt = 0;
        while (!fail && cnt < 400) begin
            step(0, 0, 0, 0, 0);
            cnt++;
            if (prev_pr && !pll_reset) begin
                if (falls < 3) f_at[falls] = cnt;
                falls++;
            end
            prev_pr = pll_reset;
        end
        check("fail_pulses", 32'(falls), 32'd3);
        check("pulse_gap1", 32'(f_at[1] - f_at[0]), 32'd36);
        check("pulse_gap2", 32'(f_at[2] - f_at[1]), 32'd36);
        check("fail_reset_held", 32'({fail, pll_reset}), 32'b11);
        step(1, 1, 6'd1, 6'd2, 6'd3);
        check("fail_cleared", 32'(fail), 32'd0);

        // Request held during WAIT_LOCK is lost on async rst.
        repeat (6) step(1, 0, 0, 0, 0);
        repeat (2) step(1, 1, 6'h2A, 6'h15, 6'h3F);
        check("wait_not_ready", 32'({cfg_if.cfg_ready, idsel, fbdsel, odsel}),
              32'({1'b0, 6'd1, 6'd2, 6'd3}));
        rst = 1'b1;
        #1;
        check("async_rst", 32'(act_vec()), 32'(RST_VEC));
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        rst = 1'b0;
        model_reset();
        dones = 0;
        for (int k = 0; k < 20; k++) begin
            step(1, 0, 0, 0, 0);
            if (cfg_if.cfg_done) dones++;
        end
        check("post_rst_sel", 32'({locked, idsel, fbdsel, odsel}), 32'({1'b1, 18'd0}));
        check("post_rst_no_done", 32'(dones), 32'd0);

        // Random lock behaviour and requests against the model.
        run = 0; lv = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (run == 0) begin
                lv  = ($urandom_range(0, 3) != 0);
                run = lv ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 12));
            end
            run--;
            step(lv, ($urandom_range(0, 19) == 0), 6'($urandom_range(0, 63)),
                 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pll_reconfig_ctrl.md
Name: pll_reconfig_ctrl

Overview:
Sequencer for a Gowin rPLL run with dynamic divider selects (IDSEL/FBDSEL/ODSEL) and RESET driven from fabric instead of tied low. It holds the PLL in reset for a fixed window, applies divider settings, and qualifies LOCK with a stability window and a timeout/retry policy. It exposes a clean lock flag and accepts runtime frequency-change requests over a valid/ready handshake. Clocked from the free-running board oscillator (27 MHz), never from a PLL output.

Parameters:
RESET_CYCLES, 16, cycles pll_reset is held high per attempt (>=2)
LOCK_STABLE_CYCLES, 256, consecutive synced-LOCK-high cycles before locked asserts
LOCK_TIMEOUT_CYCLES, 65535, max cycles in WAIT_LOCK per attempt
MAX_RETRIES, 3, extra reset attempts after the first timeout before FAIL
DEF_IDSEL, 6'd0, idsel value loaded at reset
DEF_FBDSEL, 6'd0, fbdsel value loaded at reset
DEF_ODSEL, 6'd0, odsel value loaded at reset

Ports:
clk  in  1  free-running oscillator clock
rst  in  1  asynchronous, active-high reset
pll_lock  in  1  rPLL LOCK (asynchronous to clk)
pll_reset  out  1  to rPLL RESET
idsel  out  6  to rPLL IDSEL; primitive encoding passed verbatim
fbdsel  out  6  to rPLL FBDSEL
odsel  out  6  to rPLL ODSEL
cfg_valid  in  1  new divider request
cfg_idsel  in  6  requested IDSEL
cfg_fbdsel  in  6  requested FBDSEL
cfg_odsel  in  6  requested ODSEL
cfg_ready  out  1  request accepted when cfg_valid && cfg_ready
cfg_done  out  1  one-cycle pulse when a request reaches LOCKED
locked  out  1  qualified lock; gate downstream resets with this
fail  out  1  retries exhausted; held until next accepted request or rst

Behaviour:
- pll_lock passes through a 2-flop synchronizer; all logic uses the synced value (lock_s).
- Reset values: state RESET, pll_reset=1, idsel/fbdsel/odsel=DEF_*, cfg_ready=0, cfg_done=0, locked=0, fail=0, retry_cnt=0, timers=0.
- States:
  - RESET: pll_reset=1; count RESET_CYCLES; then go to WAIT_LOCK and clear the timers.
  - WAIT_LOCK: pll_reset=0; timeout timer increments every cycle; stable counter increments while lock_s=1 and clears to 0 whenever lock_s=0.
    - Stable counter reaches LOCK_STABLE_CYCLES-1 with lock_s=1: go to LOCKED, locked=1 next cycle, retry_cnt=0, cfg_done pulses if the attempt came from an accepted request.
    - Timeout timer reaches LOCK_TIMEOUT_CYCLES-1 with retry_cnt<MAX_RETRIES: retry_cnt++, go to RESET.
    - Timeout with retry_cnt==MAX_RETRIES: go to FAIL.
    - Stable completion wins over timeout when both occur on the same cycle.
  - LOCKED: locked=1, cfg_ready=1.
    - lock_s falls: locked=0 on the next cycle, retry_cnt=0, go to RESET (automatic relock with the current settings).
    - Accepted request: go to RESET.
    - Both on the same cycle: the request wins; the new settings are applied.
  - FAIL: fail=1, pll_reset=1 held, cfg_ready=1, locked=0; leaves only on an accepted request.
- Accept: when cfg_valid && cfg_ready, register cfg_* into idsel/fbdsel/odsel, deassert locked and cfg_ready the next cycle, clear fail and retry_cnt, set the pending-done flag, enter RESET. Selects change only while pll_reset=1.
- cfg_ready=0 in RESET and WAIT_LOCK. A request held valid there waits and is not dropped.
- Counters are sized by $clog2 of their parameter and saturate; no wrap.
- rst asserted mid-operation returns everything to reset values immediately, including a pending request. That request is lost.

Optional Feature:
PLL_CTRL_STATS_EN
- Defined: adds output lock_loss_cnt (8 bits) and output retry_total (8 bits), both saturating at 255 and cleared only by rst.
  - lock_loss_cnt increments on each LOCKED->RESET transition caused by lock_s falling.
  - retry_total increments on each timeout retry.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package pll_ctrl_pkg: state enum (RESET, WAIT_LOCK, LOCKED, FAIL), PLL_SEL_W=6 constant, and a struct bundling {idsel, fbdsel, odsel}.
- One sub-module, sync_2ff: generic 2-flop bit synchronizer for pll_lock, reused elsewhere.

Test Plan:
All scenarios use RESET_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2.
1. Release rst, pll_lock=1 from time 0 -> pll_reset high exactly 4 cycles; locked rises 8 cycles after lock_s is first high; cfg_done stays 0.
2. In LOCKED, request cfg_idsel=3, fbdsel=9, odsel=8 -> idsel=3/fbdsel=9/odsel=8 next cycle with pll_reset=1; locked=0; cfg_ready=0 until relock; one cfg_done pulse.
3. pll_lock held 0 -> exactly 3 reset pulses spaced 4+32 cycles apart, then fail=1 with pll_reset=1; a new request clears fail.
4. During WAIT_LOCK, pll_lock toggles 1 for 5 cycles then 0, then stays 1 -> stable counter restarts; locked asserts 8 cycles after the final rise.
5. In LOCKED, drop pll_lock for 1 cycle -> locked falls within 3 cycles (synchronizer plus register); auto RESET keeps the same selects; relock succeeds; with PLL_CTRL_STATS_EN, lock_loss_cnt=1.
6. Assert rst during WAIT_LOCK with a request pending -> all outputs return to reset values (selects=DEF_*) asynchronously; the request is not applied.
